// File: rtl/irq_capture_stage_if.sv
// ---------------------------------------------------------------------------
// irq_capture_stage_if
//   Bundles the request, configuration, acknowledge and snapshot signals of
//   irq_capture_stage. clk and rst_n stay plain module ports.
//
//   master : the surrounding system (drives raw irqs, cfg writes, acks)
//   slave  : irq_capture_stage itself
//
//   Signals:
//     irq_a/b/c   raw 9-bit request buses, asynchronous to clk
//     cfg_we      channel-enable write strobe, cfg_wdata its value
//     ack_valid   consumer acknowledge; ack_bus (0=A,1=B,2=C), ack_chan (0..8)
//     snap_a/b/c  frozen pending vectors to the encoder, snap_en frozen enables
//     snap_valid  encoder outputs settled, busy = FSM not idle
//     ack_err     one-cycle pulse on an illegal or out-of-state ack
//   Optional (IRQ_OVERFLOW_CNT_EN): ovf_a/b/c 8-bit saturating counters,
//     ovf_clr clears them.
// ---------------------------------------------------------------------------
interface irq_capture_stage_if;
  logic [8:0] irq_a;
  logic [8:0] irq_b;
  logic [8:0] irq_c;
  logic       cfg_we;
  logic [8:0] cfg_wdata;
  logic       ack_valid;
  logic [1:0] ack_bus;
  logic [3:0] ack_chan;
  logic [8:0] snap_a;
  logic [8:0] snap_b;
  logic [8:0] snap_c;
  logic [8:0] snap_en;
  logic       snap_valid;
  logic       busy;
  logic       ack_err;
`ifdef IRQ_OVERFLOW_CNT_EN
  logic [7:0] ovf_a;
  logic [7:0] ovf_b;
  logic [7:0] ovf_c;
  logic       ovf_clr;

  modport master (
    output irq_a, irq_b, irq_c, cfg_we, cfg_wdata,
    output ack_valid, ack_bus, ack_chan, ovf_clr,
    input  snap_a, snap_b, snap_c, snap_en, snap_valid, busy, ack_err,
    input  ovf_a, ovf_b, ovf_c
  );

  modport slave (
    input  irq_a, irq_b, irq_c, cfg_we, cfg_wdata,
    input  ack_valid, ack_bus, ack_chan, ovf_clr,
    output snap_a, snap_b, snap_c, snap_en, snap_valid, busy, ack_err,
    output ovf_a, ovf_b, ovf_c
  );
`else
  modport master (
    output irq_a, irq_b, irq_c, cfg_we, cfg_wdata,
    output ack_valid, ack_bus, ack_chan,
    input  snap_a, snap_b, snap_c, snap_en, snap_valid, busy, ack_err
  );

  modport slave (
    input  irq_a, irq_b, irq_c, cfg_we, cfg_wdata,
    input  ack_valid, ack_bus, ack_chan,
    output snap_a, snap_b, snap_c, snap_en, snap_valid, busy, ack_err
  );
`endif
endinterface

// File: rtl/irq_capture_stage.sv
// ---------------------------------------------------------------------------
// irq_capture_stage
//   Front end of the 27-channel priority interrupt encoder. Synchronises the
//   three raw 9-bit request buses, latches requests as pending bits, and
//   presents a frozen snapshot (pending vectors + channel enables) to the
//   combinational encoder until the consumer acknowledges a channel.
//
//   Ports:
//     clk     single clock
//     rst_n   asynchronous active-low reset
//     irq_if  irq_capture_stage_if.slave (requests, cfg, ack, snapshot)
//
//   Parameters:
//     SYNC_STAGES   synchroniser depth (>= 2)
//     SETTLE_CYCLES snapshot hold before snap_valid (1..15)
//     LEVEL_MODE    0 = rising-edge capture, 1 = level capture
//
//   Optional macro IRQ_OVERFLOW_CNT_EN adds per-bus saturating counters of
//   capture events that hit an already-pending bit (ovf_a/b/c, ovf_clr).
// ---------------------------------------------------------------------------
module irq_capture_stage #(
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned LEVEL_MODE    = 0
) (
  input logic                clk,
  input logic                rst_n,
  irq_capture_stage_if.slave irq_if
);

  localparam int unsigned N = 27;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_WAIT   = 2'd2
  } state_e;

  // Raw lines flattened as {C, B, A}; bit index = bus*9 + channel.
  logic [N-1:0] raw;
  assign raw = {irq_if.irq_c, irq_if.irq_b, irq_if.irq_a};

  // -------------------------------------------------------------------------
  // Synchroniser and capture-event detection
  // -------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0][N-1:0] sync_q;
  logic [N-1:0]                  sync_s;
  logic [N-1:0]                  prev_q;
  logic [N-1:0]                  cap;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= '0;
    end else begin
      sync_q[0] <= raw;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      prev_q <= sync_s;
    end
  end

  assign sync_s = sync_q[SYNC_STAGES-1];

  always_comb begin
    if (LEVEL_MODE != 0) cap = sync_s;
    else                 cap = sync_s & ~prev_q;
  end

  // -------------------------------------------------------------------------
  // Acknowledge decode
  // -------------------------------------------------------------------------
  state_e     state_q, state_d;
  logic       ack_legal;
  logic       ack_ok;
  logic [8:0] ack_onehot;
  logic [N-1:0] clr;

  assign ack_legal  = (irq_if.ack_bus != 2'd3) && (irq_if.ack_chan <= 4'd8);
  assign ack_ok     = irq_if.ack_valid && ack_legal && (state_q == ST_WAIT);
  assign ack_onehot = 9'd1 << irq_if.ack_chan;

  always_comb begin
    clr = '0;
    if (ack_ok) begin
      case (irq_if.ack_bus)
        2'd0:    clr[8:0]   = ack_onehot;
        2'd1:    clr[17:9]  = ack_onehot;
        2'd2:    clr[26:18] = ack_onehot;
        default: clr        = '0;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Pending bits (set wins over clear) and channel-enable register
  // -------------------------------------------------------------------------
  logic [N-1:0] pend_q, pend_d;
  logic [8:0]   chan_en_q;

  assign pend_d = (pend_q & ~clr) | cap;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q    <= '0;
      chan_en_q <= '1;
    end else begin
      pend_q <= pend_d;
      if (irq_if.cfg_we) chan_en_q <= irq_if.cfg_wdata;
    end
  end

  // -------------------------------------------------------------------------
  // Snapshot FSM
  // -------------------------------------------------------------------------
  logic [3:0]   cnt_q, cnt_d;
  logic [N-1:0] snap_q, snap_d;
  logic [8:0]   snap_en_q, snap_en_d;
  logic         snap_valid_q, snap_valid_d;
  logic         ack_err_q, ack_err_d;
  logic         req_any;

  // Load only when at least one enabled channel is pending on any bus.
  assign req_any = |((pend_q[8:0] | pend_q[17:9] | pend_q[26:18]) & chan_en_q);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    snap_d       = snap_q;
    snap_en_d    = snap_en_q;
    snap_valid_d = 1'b0;
    ack_err_d    = irq_if.ack_valid && !ack_ok;
    case (state_q)
      ST_IDLE: begin
        if (req_any) begin
          snap_d    = pend_q;
          snap_en_d = chan_en_q;
          cnt_d     = 4'(SETTLE_CYCLES - 1);
          state_d   = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (cnt_q == 4'd0) state_d = ST_WAIT;
        else               cnt_d   = cnt_q - 4'd1;
      end
      ST_WAIT: begin
        // snap_valid registers one cycle after entering WAIT, so it first
        // rises SETTLE_CYCLES+1 edges after the load edge.
        if (ack_ok) state_d      = ST_IDLE;
        else        snap_valid_d = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      snap_q       <= '0;
      snap_en_q    <= '0;
      snap_valid_q <= 1'b0;
      ack_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      snap_q       <= snap_d;
      snap_en_q    <= snap_en_d;
      snap_valid_q <= snap_valid_d;
      ack_err_q    <= ack_err_d;
    end
  end

  assign irq_if.snap_a     = snap_q[8:0];
  assign irq_if.snap_b     = snap_q[17:9];
  assign irq_if.snap_c     = snap_q[26:18];
  assign irq_if.snap_en    = snap_en_q;
  assign irq_if.snap_valid = snap_valid_q;
  assign irq_if.busy       = (state_q != ST_IDLE);
  assign irq_if.ack_err    = ack_err_q;

`ifdef IRQ_OVERFLOW_CNT_EN
  // -------------------------------------------------------------------------
  // Overflow counters: one increment per bus per cycle, saturating at 255
  // -------------------------------------------------------------------------
  logic [2:0]      hit;
  logic [2:0][7:0] ovf_q;

  assign hit[0] = |(cap[8:0]   & pend_q[8:0]);
  assign hit[1] = |(cap[17:9]  & pend_q[17:9]);
  assign hit[2] = |(cap[26:18] & pend_q[26:18]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= '0;
    end else begin
      for (int unsigned b = 0; b < 3; b++) begin
        if (irq_if.ovf_clr)                      ovf_q[b] <= '0;
        else if (hit[b] && (ovf_q[b] != 8'hFF))  ovf_q[b] <= ovf_q[b] + 8'd1;
      end
    end
  end

  assign irq_if.ovf_a = ovf_q[0];
  assign irq_if.ovf_b = ovf_q[1];
  assign irq_if.ovf_c = ovf_q[2];
`endif

endmodule

// File: tb/tb_irq_capture_stage.sv
module tb_irq_capture_stage;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  irq_capture_stage_if u_if ();

  irq_capture_stage #(
    .SYNC_STAGES  (2),
    .SETTLE_CYCLES(2),
    .LEVEL_MODE   (0)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .irq_if(u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic ack(input logic [1:0] bus, input logic [3:0] chan);
    u_if.ack_valid = 1'b1;
    u_if.ack_bus   = bus;
    u_if.ack_chan  = chan;
    tick();
    u_if.ack_valid = 1'b0;
  endtask

  initial begin
    n_checks        = 0;
    n_errors        = 0;
    rst_n           = 1'b0;
    u_if.irq_a      = '0;
    u_if.irq_b      = '0;
    u_if.irq_c      = '0;
    u_if.cfg_we     = 1'b0;
    u_if.cfg_wdata  = '0;
    u_if.ack_valid  = 1'b0;
    u_if.ack_bus    = '0;
    u_if.ack_chan   = '0;
`ifdef IRQ_OVERFLOW_CNT_EN
    u_if.ovf_clr    = 1'b0;
`endif

    // Reset state
    ticks(2);
    check_eq("rst_busy",    u_if.busy, 0);
    check_eq("rst_valid",   u_if.snap_valid, 0);
    check_eq("rst_ackerr",  u_if.ack_err, 0);
    rst_n = 1'b1;
    ticks(4);
    check_eq("idle_busy",   u_if.busy, 0);
    check_eq("idle_valid",  u_if.snap_valid, 0);
    check_eq("idle_snap_a", u_if.snap_a, 0);
    check_eq("idle_snap_en", u_if.snap_en, 0);
    check_eq("idle_chan_en", dut.chan_en_q, 9'h1FF);

    // Single request on A[3]: pending after 3 edges, load on the 4th
    u_if.irq_a = 9'h008;
    ticks(2);
    check_eq("a3_pend_early", dut.pend_q[8:0], 0);
    tick();
    check_eq("a3_pend",      dut.pend_q[8:0], 9'h008);
    check_eq("a3_busy_pre",  u_if.busy, 0);
    tick();
    check_eq("a3_snap_a",    u_if.snap_a, 9'h008);
    check_eq("a3_snap_en",   u_if.snap_en, 9'h1FF);
    check_eq("a3_busy",      u_if.busy, 1);
    check_eq("a3_valid_l0",  u_if.snap_valid, 0);
    tick();
    check_eq("a3_valid_l1",  u_if.snap_valid, 0);
    tick();
    check_eq("a3_valid_l2",  u_if.snap_valid, 0);
    tick();
    check_eq("a3_valid_l3",  u_if.snap_valid, 1);
    ack(2'd0, 4'd3);
    check_eq("a3_ack_valid", u_if.snap_valid, 0);
    check_eq("a3_ack_busy",  u_if.busy, 0);
    check_eq("a3_ack_pend",  dut.pend_q[8:0], 0);
    check_eq("a3_ack_err",   u_if.ack_err, 0);
    tick();
    check_eq("a3_no_reload", u_if.busy, 0);
    u_if.irq_a = '0;

    // Masked channel, then unmask
    u_if.cfg_we    = 1'b1;
    u_if.cfg_wdata = 9'h1F7;
    tick();
    u_if.cfg_we    = 1'b0;
    check_eq("mask_chan_en", dut.chan_en_q, 9'h1F7);
    u_if.irq_b = 9'h008;
    ticks(3);
    check_eq("mask_pend_b",  dut.pend_q[17:9], 9'h008);
    ticks(2);
    check_eq("mask_idle",    u_if.busy, 0);
    u_if.cfg_we    = 1'b1;
    u_if.cfg_wdata = 9'h1FF;
    tick();
    u_if.cfg_we    = 1'b0;
    check_eq("unmask_old_en", u_if.busy, 0);
    tick();
    check_eq("unmask_busy",  u_if.busy, 1);
    check_eq("unmask_snap_b", u_if.snap_b, 9'h008);
    check_eq("unmask_snap_a", u_if.snap_a, 0);
    check_eq("unmask_snap_en", u_if.snap_en, 9'h1FF);
    u_if.irq_b = '0;
    ticks(2);
    check_eq("unmask_valid_l2", u_if.snap_valid, 0);
    tick();
    check_eq("unmask_valid_l3", u_if.snap_valid, 1);

    // New request on C[8] during WAIT: pending only, snapshot frozen
    u_if.irq_c = 9'h100;
    tick();
    u_if.irq_c = '0;
    ticks(2);
    check_eq("wait_pend_c",  dut.pend_q[26:18], 9'h100);
    check_eq("wait_snap_c",  u_if.snap_c, 0);
    check_eq("wait_valid",   u_if.snap_valid, 1);

    // Illegal acks in WAIT
    ack(2'd1, 4'd9);
    check_eq("ill_chan_err",   u_if.ack_err, 1);
    check_eq("ill_chan_valid", u_if.snap_valid, 1);
    check_eq("ill_chan_pend",  dut.pend_q[17:9], 9'h008);
    tick();
    check_eq("ill_err_pulse",  u_if.ack_err, 0);
    check_eq("ill_still_busy", u_if.busy, 1);
    ack(2'd3, 4'd3);
    check_eq("ill_bus_err",    u_if.ack_err, 1);
    check_eq("ill_bus_valid",  u_if.snap_valid, 1);

    // Legal ack of B[3], reload with C[8] next cycle
    ack(2'd1, 4'd3);
    check_eq("b3_ack_valid", u_if.snap_valid, 0);
    check_eq("b3_ack_busy",  u_if.busy, 0);
    check_eq("b3_ack_pend",  dut.pend_q[17:9], 0);
    tick();
    check_eq("c8_reload_busy", u_if.busy, 1);
    check_eq("c8_snap_c",    u_if.snap_c, 9'h100);
    check_eq("c8_snap_b",    u_if.snap_b, 0);

    // Ack while in SETTLE is out of state
    ack(2'd2, 4'd8);
    check_eq("settle_ack_err",  u_if.ack_err, 1);
    check_eq("settle_ack_pend", dut.pend_q[26:18], 9'h100);
    check_eq("settle_busy",     u_if.busy, 1);
    tick();
    check_eq("settle_valid_l2", u_if.snap_valid, 0);
    tick();
    check_eq("settle_valid_l3", u_if.snap_valid, 1);

    // Legal ack of a non-pending channel still returns to IDLE
    ack(2'd0, 4'd5);
    check_eq("zero_ack_busy",  u_if.busy, 0);
    check_eq("zero_ack_err",   u_if.ack_err, 0);
    check_eq("zero_ack_pend",  dut.pend_q[26:18], 9'h100);
    tick();
    check_eq("zero_reload",    u_if.busy, 1);
    ticks(3);
    check_eq("c8_valid2",      u_if.snap_valid, 1);
    ack(2'd2, 4'd8);
    check_eq("c8_ack_pend",    dut.pend_q[26:18], 0);
    tick();
    check_eq("c8_idle",        u_if.busy, 0);

    // Ack in IDLE
    ack(2'd0, 4'd0);
    check_eq("idle_ack_err",   u_if.ack_err, 1);
    check_eq("idle_ack_busy",  u_if.busy, 0);
    tick();
    check_eq("idle_ack_pulse", u_if.ack_err, 0);

    // Set and clear of the same pending bit in the same cycle: set wins
    u_if.irq_a = 9'h004;
    tick();
    u_if.irq_a = '0;
    ticks(6);
    check_eq("sw_valid",      u_if.snap_valid, 1);
    u_if.irq_a = 9'h004;
    ticks(2);
    ack(2'd0, 4'd2);
    check_eq("sw_idle",       u_if.busy, 0);
    check_eq("sw_pend",       dut.pend_q[8:0], 9'h004);
    tick();
    check_eq("sw_reload",     u_if.busy, 1);

    // Asynchronous reset mid-operation
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("arst_busy",     u_if.busy, 0);
    check_eq("arst_snap_a",   u_if.snap_a, 0);
    check_eq("arst_pend",     dut.pend_q, 0);
    check_eq("arst_chan_en",  dut.chan_en_q, 9'h1FF);
    u_if.irq_a = '0;
    tick();
    rst_n = 1'b1;
    ticks(4);
    check_eq("arst_stay_idle", u_if.busy, 0);

`ifdef IRQ_OVERFLOW_CNT_EN
    // 300 edges on A[0] without ack: saturate at 255
    for (int i = 0; i < 300; i++) begin
      u_if.irq_a = 9'h001;
      tick();
      u_if.irq_a = '0;
      tick();
    end
    ticks(4);
    check_eq("ovf_a_sat",   u_if.ovf_a, 8'd255);
    check_eq("ovf_b_zero",  u_if.ovf_b, 8'd0);
    check_eq("ovf_c_zero",  u_if.ovf_c, 8'd0);
    // Clear has priority over concurrent hits
    u_if.ovf_clr = 1'b1;
    for (int i = 0; i < 4; i++) begin
      u_if.irq_a = 9'h001;
      tick();
      u_if.irq_a = '0;
      tick();
    end
    check_eq("ovf_a_clr",   u_if.ovf_a, 8'd0);
    u_if.ovf_clr = 1'b0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/irq_capture_stage.md
Name: irq_capture_stage

Overview:
- Front-end stage directly upstream of the c432_blif 27-channel priority interrupt encoder.
- Synchronises 27 raw interrupt lines (three buses A/B/C, 9 channels each) and latches them as pending bits.
- Applies a 9-bit per-channel enable register, then presents a frozen snapshot to the combinational encoder while it settles and until the consumer acknowledges the serviced channel.
- Encoder-side pin mapping of the snapshot vectors is done in top-level wiring and is not part of this block.

Parameters:
- SYNC_STAGES, 2, number of synchroniser flops per raw line; legal values >= 2.
- SETTLE_CYCLES, 2, cycles the snapshot is held before snap_valid asserts; legal range 1..15.
- LEVEL_MODE, 0, 0 = rising-edge capture, 1 = level capture.

Ports:
- clk  in  1  single clock.
- rst_n  in  1  asynchronous, active-low reset.
- irq_a  in  9  raw requests, bus A, asynchronous to clk.
- irq_b  in  9  raw requests, bus B, asynchronous to clk.
- irq_c  in  9  raw requests, bus C, asynchronous to clk.
- cfg_we  in  1  write strobe for the channel-enable register.
- cfg_wdata  in  9  new channel-enable value.
- ack_valid  in  1  consumer acknowledges the serviced channel.
- ack_bus  in  2  bus being acknowledged: 0=A, 1=B, 2=C; 3 is illegal.
- ack_chan  in  4  channel being acknowledged, 0..8; 9..15 are illegal.
- snap_a  out  9  frozen pending vector for bus A, to encoder.
- snap_b  out  9  frozen pending vector for bus B, to encoder.
- snap_c  out  9  frozen pending vector for bus C, to encoder.
- snap_en  out  9  frozen channel-enable vector, to encoder.
- snap_valid  out  1  encoder outputs are settled and may be sampled.
- busy  out  1  FSM is not in IDLE.
- ack_err  out  1  one-cycle pulse on an illegal or out-of-state ack.

Behaviour:
- Reset (async assert, sync deassert): all synchroniser, pending, snapshot and FSM registers go to 0; chan_en register resets to 9'h1FF; snap_en = 0; snap_valid, busy and ack_err = 0; state = IDLE.
- Synchroniser: SYNC_STAGES flops per line. With default parameters, a raw edge reaches the pending bit 3 clk edges later (2 synchroniser flops + 1 edge-detect flop).
- Edge mode: a rising edge of a synchronised line sets its pending bit.
- Level mode: a pending bit is set on every cycle its synchronised line is high.
- A pending bit stays set until it is acknowledged.
- A set and a clear of the same pending bit in the same cycle: set wins.
- cfg_we writes chan_en on the next edge. Write-and-load in the same cycle: the snapshot takes the old chan_en value.
- FSM states: IDLE, SETTLE, WAIT.
- IDLE: if (pend_a|pend_b|pend_c) & chan_en != 0:
  - load snap_a/b/c <= pending vectors (unmasked) and snap_en <= chan_en;
  - load the settle counter with SETTLE_CYCLES-1;
  - go to SETTLE.
- SETTLE:
  - snapshot registers are frozen;
  - counter decrements each cycle;
  - at count 0, go to WAIT and assert snap_valid (registered). snap_valid is therefore first high SETTLE_CYCLES+1 cycles after the load edge.
- WAIT:
  - snap_valid = 1, snapshot frozen;
  - on ack_valid with a legal bus and channel: clear that pending bit, deassert snap_valid, go to IDLE;
  - IDLE may reload on the very next cycle.
- Illegal ack (ack_bus=3 or ack_chan>8), or ack_valid while in IDLE or SETTLE: ack_err pulses for 1 cycle; no state change; no pending bit is cleared.
- An ack of a channel whose pending bit is already 0 is legal; the FSM still returns to IDLE.
- New requests arriving during SETTLE or WAIT update the pending bits only; the snapshot is not refreshed.
- busy = (state != IDLE).
- rst_n asserted mid-operation: the block returns immediately to reset values. Pending requests are lost.

Optional Feature:
- Macro: IRQ_OVERFLOW_CNT_EN.
- When defined:
  - adds ports ovf_a, ovf_b, ovf_c (out, 8 bits each) and ovf_clr (in, 1 bit);
  - each counter increments when a capture event hits an already-pending bit on its bus; in edge mode this is a rising edge, in level mode a high cycle;
  - multiple hits on one bus in the same cycle count as 1;
  - counters saturate at 255;
  - ovf_clr zeroes all three counters; clear has priority over increment;
  - counters reset to 0.
- When undefined: no extra ports or logic; behaviour is otherwise identical.

Test Plan:
- Reset, rst_n released, no irq -> chan_en=9'h1FF; snap_*=0; busy=0; snap_valid=0 indefinitely.
- irq_a[3] rises at cycle 0 (defaults) -> pend_a[3]=1 after 3 edges; next cycle snap_a=9'h008, busy=1; snap_valid=1 exactly 3 cycles after load; ack_bus=0, ack_chan=3 -> snap_valid=0, pend_a[3]=0, IDLE.
- cfg_wdata=9'h1F7 written, then irq_b[3] raised -> pending set but channel masked, FSM stays IDLE; then write 9'h1FF -> load occurs with snap_b=9'h008.
- In WAIT, pulse irq_c[8] -> pend_c[8]=1 but snap_c stays 0. After ack, IDLE reloads with snap_c=9'h100 on the following cycle.
- ack_valid with ack_chan=9 in WAIT, and ack_valid in IDLE -> single-cycle ack_err each time; state and pending bits unchanged.
- IRQ_OVERFLOW_CNT_EN: 300 edges on irq_a[0] with no ack -> ovf_a saturates at 255; assert ovf_clr together with a new hit -> ovf_a=0.
